frame_xmit: RTL

- Serial frame transmitter that sits directly upstream of the serial receiver.
- Accepts parallel bytes through a load/ready handshake and emits each byte on a 1-bit line as a 16-bit frame: the 8-bit MATCH header, then the 8 data bits, both MSB first.
- Consecutive frames go out back-to-back with no gap. The line idles at 0 between frames.
- The frame format is chosen so the receiver's header hunt and 8-bit body shift line up exactly.

---
 rtl/frame_xmit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/frame_xmit.sv
// -----------------------------------------------------------------------------
// frame_xmit
//   Serial frame transmitter. Parallel bytes enter through a load/ready
//   handshake. Each byte leaves on a 1-bit line as a 16-bit frame: the MATCH
//   header, then the data byte, both MSB first. Frames run back-to-back with
//   no gap. The line idles at 0, and that level can never form MATCH, so a
//   downstream receiver stays in its header hunt between frames.
//
//   Optional build macro:
//     FRAME_XMIT_FIFO_EN - turns the single-entry holding buffer into a
//                          4-entry FIFO. A load and a pop on the same edge
//                          both take effect.
//
//   Parameters:
//     MATCH       header byte placed in front of every frame
//
//   Ports:
//     clock       system clock; all logic runs on the rising edge
//     reset       synchronous, active-high reset
//     data_in     byte to transmit
//     load        request to accept data_in this cycle
//     clear       clears the sticky overrun flag
//     ready       the buffer can accept a byte this cycle (state before edge)
//     overrun     sticky flag; set when a load was dropped
//     busy        a frame is currently on serial_out
//     serial_out  registered serial bitstream
// -----------------------------------------------------------------------------
module frame_xmit #(
  parameter logic [7:0] MATCH = 8'hA5
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       load,
  input  logic       clear,
  output logic       ready,
  output logic       overrun,
  output logic       busy,
  output logic       serial_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HEAD = 2'd1;
  localparam logic [1:0] S_BODY = 2'd2;

  logic [1:0]  r_state;
  logic [2:0]  r_cnt;
  logic [15:0] r_shift;
  logic        r_ovr;

  logic        w_have;       // buffer holds at least one byte
  logic [7:0]  w_head;       // oldest buffered byte
  logic        w_push;       // load accepted this edge
  logic        w_drop;       // load refused this edge
  logic        w_frame_end;  // the last body bit is on the line
  logic        w_pop;        // buffer-to-shifter transfer this edge

  assign w_frame_end = (r_state == S_BODY) && (r_cnt == 3'd7);
  // A byte is taken either from idle or exactly at the end of a frame,
  // which makes back-to-back frames contiguous.
  assign w_pop       = w_have && ((r_state == S_IDLE) || w_frame_end);
  assign w_drop      = load && !ready;

`ifdef FRAME_XMIT_FIFO_EN
  // ---------------------------------------------------------------------------
  // 4-entry FIFO. The 2-bit pointers wrap naturally. The occupancy count
  // tells full from empty when the pointers are equal.
  // ---------------------------------------------------------------------------
  logic [7:0] r_mem [4];
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;

  assign ready  = (r_count != 3'd4);
  assign w_have = (r_count != 3'd0);
  assign w_head = r_mem[r_rptr];
  // Acceptance depends only on the count before the edge, so a pop on the
  // same edge does not block a load, and a full FIFO still refuses it.
  assign w_push = load && ready;

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Single holding register. ready reflects the state before the edge, so a
  // load that lands on a transfer edge is refused even though the buffer
  // empties on that same edge.
  // ---------------------------------------------------------------------------
  logic       r_full;
  logic [7:0] r_buf;

  assign ready  = ~r_full;
  assign w_have = r_full;
  assign w_head = r_buf;
  assign w_push = load && ~r_full;

  always_ff @(posedge clock) begin
    if (w_push) r_buf <= data_in;
  end

  always_ff @(posedge clock) begin
    if (reset)       r_full <= 1'b0;
    else if (w_push) r_full <= 1'b1;
    else if (w_pop)  r_full <= 1'b0;
  end
`endif

  // ---------------------------------------------------------------------------
  // Sticky overrun flag. A drop overrides a simultaneous clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset)       r_ovr <= 1'b0;
    else if (w_drop) r_ovr <= 1'b1;
    else if (clear)  r_ovr <= 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Frame sequencer. serial_out is bit 15 of the shifter. The shifter is all
  // zeros while idle, which gives the 0 idle level.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_have) begin
            r_shift <= {MATCH, w_head};
            r_cnt   <= 3'd0;
            r_state <= S_HEAD;
          end
        end
        S_HEAD: begin
          r_shift <= {r_shift[14:0], 1'b0};
          r_cnt   <= r_cnt + 3'd1;  // wraps to 0 as the body starts
          if (r_cnt == 3'd7) r_state <= S_BODY;
        end
        S_BODY: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt == 3'd7) begin
            if (w_have) begin
              // Reload with no idle bit between frames.
              r_shift <= {MATCH, w_head};
              r_state <= S_HEAD;
            end else begin
              r_shift <= 16'd0;
              r_state <= S_IDLE;
            end
          end else begin
            r_shift <= {r_shift[14:0], 1'b0};
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= 3'd0;
          r_shift <= 16'd0;
        end
      endcase
    end
  end

  assign busy       = (r_state != S_IDLE);
  assign serial_out = r_shift[15];
  assign overrun    = r_ovr;

endmodule
